frame_scheduler: RTL and testbench

Sequences one rendered frame through the ray-tracing core. On `start` it snapshots the six camera registers produced by the UART camera parser, then issues one pixel request per screen position in raster order over a valid/ready handshake. It caps the number of rays in flight, waits for every issued ray to retire, and pulses `frame_done`. The block sits between the camera parser, the host-side start logic and the ray-generation pipeline.

---
 rtl/ray_pkg.sv | 20 ++
 rtl/frame_scheduler_if.sv | 37 +++
 rtl/raster_counter.sv | 40 ++++
 rtl/frame_scheduler.sv | 136 +++++++++++++
 tb/tb_frame_scheduler.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ray_pkg.sv
// Shared types for the frame scheduler slice.
//   sched_state_t : scheduler FSM state encoding
//   cam_vec_t     : one 3-component camera vector (x, y, z), 32 bits each
package ray_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } cam_vec_t;

endpackage

// File: rtl/frame_scheduler_if.sv
// Pixel request channel from the frame scheduler to the ray-generation pipeline.
//   pix_valid / pix_ready : request handshake
//   pix_x / pix_y         : requested screen position
//   ray_pos_* / ray_dir_* : camera snapshot for the frame in progress
// master = scheduler side, slave = ray-generation side.
interface frame_scheduler_if #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
);
    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);

    logic          pix_valid;
    logic          pix_ready;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [31:0]   ray_pos_x;
    logic [31:0]   ray_pos_y;
    logic [31:0]   ray_pos_z;
    logic [31:0]   ray_dir_x;
    logic [31:0]   ray_dir_y;
    logic [31:0]   ray_dir_z;

    modport master (
        output pix_valid, pix_x, pix_y,
        output ray_pos_x, ray_pos_y, ray_pos_z,
        output ray_dir_x, ray_dir_y, ray_dir_z,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_x, pix_y,
        input  ray_pos_x, ray_pos_y, ray_pos_z,
        input  ray_dir_x, ray_dir_y, ray_dir_z,
        output pix_ready
    );
endinterface

// File: rtl/raster_counter.sv
// Raster-order screen position counter.
//   clk, reset : clock, synchronous active-high reset
//   clr        : return to (0,0)
//   adv        : step to the next position in raster order
//   x, y       : current position
//   last       : current position is the final pixel of the frame
// At the final pixel the position holds even if adv is asserted.
module raster_counter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     adv,
    output logic [$clog2(H_RES)-1:0] x,
    output logic [$clog2(V_RES)-1:0] y,
    output logic                     last
);
    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

    assign last = (x == X_MAX) && (y == Y_MAX);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            x <= '0;
            y <= '0;
        end else if (adv && !last) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: snapshots the camera on start, issues one pixel request
// per screen position in raster order, caps rays in flight, waits for all
// rays to retire and pulses frame_done.
//   clk, reset        : clock, synchronous active-high reset
//   cam_pos_*/dir_*   : live camera values from the parser
//   start, abort      : frame request / stop-issuing request
//   pix               : pixel request channel (master side)
//   ret_valid         : one ray retired this cycle
//   busy              : frame in progress
//   frame_done        : one-cycle completion pulse
//   frame_aborted     : the completing frame was aborted
//   ret_err           : sticky retire-underflow flag
//   frame_count       : completed frames (wraps)
//
// state | meaning
// IDLE  | waiting for start
// LATCH | snapshot camera, clear raster position and abort flag
// ISSUE | issuing pixel requests
// DRAIN | waiting for all issued rays to retire
// DONE  | frame_done pulse, bump frame_count
module frame_scheduler
    import ray_pkg::*;
#(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         cam_pos_x,
    input  logic [31:0]         cam_pos_y,
    input  logic [31:0]         cam_pos_z,
    input  logic [31:0]         cam_dir_x,
    input  logic [31:0]         cam_dir_y,
    input  logic [31:0]         cam_dir_z,
    input  logic                start,
    input  logic                abort,
    frame_scheduler_if.master   pix,
    input  logic                ret_valid,
    output logic                busy,
    output logic                frame_done,
    output logic                frame_aborted,
    output logic                ret_err,
    output logic [15:0]         frame_count
);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0] INF_MAX = IW'(MAX_INFLIGHT);

    sched_state_t  state_q, state_d;
    logic [IW-1:0] inflight_q;
    cam_vec_t      ray_pos_q, ray_dir_q;
    logic          hs;
    logic          last;

    assign pix.pix_valid = (state_q == ISSUE) && (inflight_q < INF_MAX);
    assign hs            = pix.pix_valid && pix.pix_ready;
    assign busy          = (state_q != IDLE);
    assign frame_done    = (state_q == DONE);

    assign pix.ray_pos_x = ray_pos_q.x;
    assign pix.ray_pos_y = ray_pos_q.y;
    assign pix.ray_pos_z = ray_pos_q.z;
    assign pix.ray_dir_x = ray_dir_q.x;
    assign pix.ray_dir_y = ray_dir_q.y;
    assign pix.ray_dir_z = ray_dir_q.z;

    raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_raster (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == LATCH),
        .adv   (hs),
        .x     (pix.pix_x),
        .y     (pix.pix_y),
        .last  (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LATCH;
            LATCH:   state_d = ISSUE;
            ISSUE:   if ((hs && last) || abort) state_d = DRAIN;
            DRAIN:   if (inflight_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue is gated by inflight < MAX, so the increment path cannot overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= '0;
            ret_err    <= 1'b0;
        end else if (hs && !ret_valid) begin
            inflight_q <= inflight_q + 1'b1;
        end else if (!hs && ret_valid) begin
            if (inflight_q == '0) begin
                ret_err <= 1'b1;
            end else begin
                inflight_q <= inflight_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ray_pos_q     <= '0;
            ray_dir_q     <= '0;
            frame_aborted <= 1'b0;
            frame_count   <= '0;
        end else begin
            if (state_q == LATCH) begin
                ray_pos_q     <= {cam_pos_x, cam_pos_y, cam_pos_z};
                ray_dir_q     <= {cam_dir_x, cam_dir_y, cam_dir_z};
                frame_aborted <= 1'b0;
            end
            if (state_q == ISSUE && abort) begin
                frame_aborted <= 1'b1;
            end
            if (state_q == DONE) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler with H_RES=4, V_RES=2, MAX_INFLIGHT=2.
// Expected pixel requests and frame completions are queued by the stimulus;
// a forked monitor pops and compares whenever a handshake or frame_done occurs.
module tb_frame_scheduler;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int MI = 2;

    typedef struct {
        int          x;
        int          y;
        logic [31:0] px;
    } req_t;

    logic        clk;
    logic        reset;
    logic [31:0] cam_pos_x, cam_pos_y, cam_pos_z;
    logic [31:0] cam_dir_x, cam_dir_y, cam_dir_z;
    logic        start, abort;
    logic        auto_ret, man_ret, auto_mode;
    logic        ret_valid;
    logic        busy, frame_done, frame_aborted, ret_err;
    logic [15:0] frame_count;

    int   n_vec, n_err;
    int   hs_count, frames_seen, cyc, span_first, span_last;
    req_t exp_q[$];
    logic done_q[$];

    assign ret_valid = auto_ret | man_ret;

    frame_scheduler_if #(.H_RES(H), .V_RES(V)) pix ();

    frame_scheduler #(
        .H_RES        (H),
        .V_RES        (V),
        .MAX_INFLIGHT (MI)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cam_pos_x     (cam_pos_x),
        .cam_pos_y     (cam_pos_y),
        .cam_pos_z     (cam_pos_z),
        .cam_dir_x     (cam_dir_x),
        .cam_dir_y     (cam_dir_y),
        .cam_dir_z     (cam_dir_z),
        .start         (start),
        .abort         (abort),
        .pix           (pix),
        .ret_valid     (ret_valid),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_aborted (frame_aborted),
        .ret_err       (ret_err),
        .frame_count   (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input int x, input int y, input logic [31:0] px);
        req_t r;
        r.x  = x;
        r.y  = y;
        r.px = px;
        exp_q.push_back(r);
    endtask

    task automatic monitor_loop();
        logic hs_seen;
        req_t e;
        forever begin
            @(negedge clk);
            cyc++;
            hs_seen = pix.pix_valid && pix.pix_ready;
            if (hs_seen) begin
                hs_count++;
                if (span_first < 0) span_first = cyc;
                span_last = cyc;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_req: got (%0d,%0d), expected no request",
                             pix.pix_x, pix.pix_y);
                end else begin
                    e = exp_q.pop_front();
                    check("req_x",   64'(pix.pix_x),     64'(e.x));
                    check("req_y",   64'(pix.pix_y),     64'(e.y));
                    check("req_ray", 64'(pix.ray_pos_x), 64'(e.px));
                end
            end
            if (frame_done) begin
                frames_seen++;
                if (done_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got frame_done=1, expected 0");
                end else begin
                    check("done_aborted", 64'(frame_aborted), 64'(done_q.pop_front()));
                end
            end
            @(posedge clk);
            #1;
            auto_ret = auto_mode && hs_seen;
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && frames_seen < target; i++) tick();
        check("frame_done_seen", 64'(frames_seen), 64'(target));
    endtask

    task automatic check_reset_vals();
        check("rst_pix_valid", 64'(pix.pix_valid),   64'd0);
        check("rst_busy",      64'(busy),            64'd0);
        check("rst_done",      64'(frame_done),      64'd0);
        check("rst_aborted",   64'(frame_aborted),   64'd0);
        check("rst_ret_err",   64'(ret_err),         64'd0);
        check("rst_pix_x",     64'(pix.pix_x),       64'd0);
        check("rst_pix_y",     64'(pix.pix_y),       64'd0);
        check("rst_count",     64'(frame_count),     64'd0);
        check("rst_ray_pos",   {pix.ray_pos_x, pix.ray_pos_y ^ pix.ray_pos_z}, 64'd0);
        check("rst_ray_dir",   {pix.ray_dir_x, pix.ray_dir_y ^ pix.ray_dir_z}, 64'd0);
    endtask

    int base;

    initial begin
        n_vec = 0; n_err = 0;
        hs_count = 0; frames_seen = 0; cyc = 0; span_first = -1; span_last = -1;
        auto_ret = 1'b0; man_ret = 1'b0; auto_mode = 1'b0;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        pix.pix_ready = 1'b0;
        cam_pos_x = 32'd5;  cam_pos_y = 32'd6;  cam_pos_z = 32'd7;
        cam_dir_x = 32'd11; cam_dir_y = 32'd12; cam_dir_z = 32'd13;
        fork
            monitor_loop();
        join_none

        tick();
        tick();
        check_reset_vals();
        reset = 1'b0;
        tick();

        // Frame 1: full throughput, retire one cycle after each handshake,
        // camera changed mid-frame must not reach ray_*.
        for (int i = 0; i < H * V; i++) push_req(i % H, i / H, 32'd5);
        done_q.push_back(1'b0);
        auto_mode = 1'b1;
        pix.pix_ready = 1'b1;
        base = hs_count;
        span_first = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("latch_pix_valid", 64'(pix.pix_valid), 64'd0);
        check("latch_busy",      64'(busy),          64'd1);
        tick();
        check("first_pix_valid", 64'(pix.pix_valid), 64'd1);
        check("first_xy",        {32'(pix.pix_x), 32'(pix.pix_y)}, 64'd0);
        check("snap_dir_z",      64'(pix.ray_dir_z), 64'd13);
        for (int i = 0; i < 60 && frames_seen < 1; i++) begin
            tick();
            if (hs_count - base == 3) cam_pos_x = 32'd9;
        end
        check("f1_done_seen",  64'(frames_seen),          64'd1);
        check("f1_req_count",  64'(hs_count - base),      64'd8);
        check("f1_span",       64'(span_last - span_first), 64'd7);
        check("f1_count",      64'(frame_count),          64'd1);
        check("f1_ray_pos_x",  64'(pix.ray_pos_x),        64'd5);
        check("f1_busy_after", 64'(busy),                 64'd0);
        auto_mode = 1'b0;

        // Frame 2: in-flight cap, stall stability, single retire, abort.
        base = hs_count;
        push_req(0, 0, 32'd9);
        push_req(1, 0, 32'd9);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("cap_req_count", 64'(hs_count - base), 64'd2);
        check("cap_pix_valid", 64'(pix.pix_valid),    64'd0);
        pix.pix_ready = 1'b0;
        man_ret = 1'b1;
        tick();
        man_ret = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 64'(pix.pix_valid), 64'd1);
            check("stall_xy",    {32'(pix.pix_x), 32'(pix.pix_y)}, {32'd2, 32'd0});
            tick();
        end
        push_req(2, 0, 32'd9);
        pix.pix_ready = 1'b1;
        tick();
        tick();
        tick();
        check("one_more_count", 64'(hs_count - base), 64'd3);
        check("one_more_valid", 64'(pix.pix_valid),   64'd0);
        pix.pix_ready = 1'b0;
        man_ret = 1'b1;
        tick();
        man_ret = 1'b0;
        push_req(3, 0, 32'd9);
        pix.pix_ready = 1'b1;
        tick();
        pix.pix_ready = 1'b0;
        man_ret = 1'b1;
        tick();
        tick();
        man_ret = 1'b0;
        push_req(0, 1, 32'd9);
        push_req(1, 1, 32'd9);
        done_q.push_back(1'b1);
        pix.pix_ready = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("abort_req_count", 64'(hs_count - base), 64'd6);
        check("abort_valid",     64'(pix.pix_valid),   64'd0);
        check("abort_busy",      64'(busy),            64'd1);
        man_ret = 1'b1;
        tick();
        tick();
        man_ret = 1'b0;
        wait_done(2, 20);
        check("f2_count",   64'(frame_count),   64'd2);
        check("f2_aborted", 64'(frame_aborted), 64'd1);
        check("f2_busy",    64'(busy),          64'd0);

        // Retire underflow in IDLE, start ignored during ISSUE, reset mid-frame.
        pix.pix_ready = 1'b0;
        man_ret = 1'b1;
        tick();
        man_ret = 1'b0;
        check("idle_ret_err", 64'(ret_err), 64'd1);
        base = hs_count;
        push_req(0, 0, 32'd9);
        push_req(1, 0, 32'd9);
        pix.pix_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("f3_req_count", 64'(hs_count - base), 64'd2);
        check("f3_cap_valid", 64'(pix.pix_valid),   64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        push_req(2, 0, 32'd9);
        man_ret = 1'b1;
        tick();
        man_ret = 1'b0;
        tick();
        tick();
        check("restart_ignored", 64'(hs_count - base), 64'd3);
        reset = 1'b1;
        tick();
        check_reset_vals();
        reset = 1'b0;
        pix.pix_ready = 1'b0;
        man_ret = 1'b1;
        tick();
        man_ret = 1'b0;
        check("post_rst_ret_err", 64'(ret_err),       64'd1);
        check("left_req_exp",     64'(exp_q.size()),  64'd0);
        check("left_done_exp",    64'(done_q.size()), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
